// File: rtl/mmu_addr_xlate.sv
// -----------------------------------------------------------------------------
// mmu_addr_xlate
//
// Two-stage virtual-to-physical address translator that sits in front of the
// CPU memory interface. Each request is classified by MIPS segment. Unmapped
// segments (kseg0/kseg1) translate directly. Mapped segments (kuseg,
// kseg2/kseg3) go through one TLB search port. The block returns a physical
// address, a cacheability flag and any TLB exception.
//
// Pipeline:
//   q1 : lookup stage. Holds {valid, vaddr, wr, asid} and drives the TLB
//        search port.
//   q2 : response stage. Holds the registered resp_* outputs.
//
// Ports:
//   clk, resetn          clock (rising edge), async active-low reset
//   flush                synchronous kill of everything in flight
//   req_*                request side, valid/ready handshake
//   s_*                  TLB search port (vpn2/odd/asid out, hit data in)
//   resp_*               response side, valid/ready handshake
// -----------------------------------------------------------------------------
module mmu_addr_xlate #(
    parameter int TLBNUM = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,

    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [31:0]                req_vaddr,
    input  logic                       req_wr,
    input  logic [7:0]                 req_asid,

    output logic [18:0]                s_vpn2,
    output logic                       s_odd_page,
    output logic [7:0]                 s_asid,
    input  logic                       s_found,
    input  logic [$clog2(TLBNUM)-1:0]  s_index,
    input  logic [19:0]                s_pfn,
    input  logic [2:0]                 s_c,
    input  logic                       s_d,
    input  logic                       s_v,

    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [31:0]                resp_paddr,
    output logic                       resp_uncached,
    output logic                       resp_ex,
    output logic [4:0]                 resp_excode,
    output logic                       resp_refill,
    output logic [31:0]                resp_badvaddr
);

    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;

    localparam logic [2:0] SEG_KSEG0 = 3'b100;
    localparam logic [2:0] SEG_KSEG1 = 3'b101;

    localparam logic [2:0] CACHE_UNCACHED = 3'd2;

    // q1 (lookup stage)
    logic        q1_valid_q, q1_valid_d;
    logic [31:0] q1_vaddr_q, q1_vaddr_d;
    logic        q1_wr_q,    q1_wr_d;
    logic [7:0]  q1_asid_q,  q1_asid_d;

    // q2 (response stage)
    logic        resp_valid_q,    resp_valid_d;
    logic [31:0] resp_paddr_q,    resp_paddr_d;
    logic        resp_uncached_q, resp_uncached_d;
    logic        resp_ex_q,       resp_ex_d;
    logic [4:0]  resp_excode_q,   resp_excode_d;
    logic        resp_refill_q,   resp_refill_d;
    logic [31:0] resp_badvaddr_q, resp_badvaddr_d;

    // Translation result for whatever currently sits in q1
    logic [31:0] x_paddr;
    logic        x_uncached;
    logic        x_ex;
    logic [4:0]  x_excode;
    logic        x_refill;
    logic [2:0]  x_seg;

    logic q2_free;
    logic q1_advance;
    logic req_accept;

    // The hit index is reserved for future use; fold it so it stays visible.
    logic unused_s_index;
    assign unused_s_index = ^s_index;

    // Handshake
    assign q2_free    = !resp_valid_q || resp_ready;
    // Gating with resetn keeps requests from being acknowledged while the
    // pipeline is held in reset.
    assign req_ready  = resetn && !flush && (!q1_valid_q || q2_free);
    assign req_accept = req_valid && req_ready;
    assign q1_advance = q1_valid_q && q2_free;

    // The search port is driven from q1 so a stalled entry re-searches every
    // cycle and always sees the current TLB contents.
    assign s_vpn2     = q1_vaddr_q[31:13];
    assign s_odd_page = q1_vaddr_q[12];
    assign s_asid     = q1_asid_q;

    // Segment decode and TLB outcome
    always_comb begin
        x_paddr    = 32'd0;
        x_uncached = 1'b0;
        x_ex       = 1'b0;
        x_excode   = 5'd0;
        x_refill   = 1'b0;
        x_seg      = q1_vaddr_q[31:29];

        if (x_seg == SEG_KSEG0) begin
            x_paddr = {3'b000, q1_vaddr_q[28:0]};
        end else if (x_seg == SEG_KSEG1) begin
            x_paddr    = {3'b000, q1_vaddr_q[28:0]};
            x_uncached = 1'b1;
        end else if (!s_found) begin
            x_ex     = 1'b1;
            x_refill = 1'b1;
            x_excode = q1_wr_q ? EXC_TLBS : EXC_TLBL;
        end else if (!s_v) begin
            x_ex     = 1'b1;
            x_excode = q1_wr_q ? EXC_TLBS : EXC_TLBL;
        end else if (q1_wr_q && !s_d) begin
            x_ex     = 1'b1;
            x_excode = EXC_MOD;
        end else begin
            x_paddr    = {s_pfn, q1_vaddr_q[11:0]};
            x_uncached = (s_c == CACHE_UNCACHED);
        end
    end

    // q1 next state
    always_comb begin
        q1_valid_d = q1_valid_q;
        q1_vaddr_d = q1_vaddr_q;
        q1_wr_d    = q1_wr_q;
        q1_asid_d  = q1_asid_q;

        if (flush) begin
            q1_valid_d = 1'b0;
        end else if (req_accept) begin
            q1_valid_d = 1'b1;
            q1_vaddr_d = req_vaddr;
            q1_wr_d    = req_wr;
            q1_asid_d  = req_asid;
        end else if (q1_advance) begin
            q1_valid_d = 1'b0;
        end
    end

    // q2 next state
    always_comb begin
        resp_valid_d    = resp_valid_q;
        resp_paddr_d    = resp_paddr_q;
        resp_uncached_d = resp_uncached_q;
        resp_ex_d       = resp_ex_q;
        resp_excode_d   = resp_excode_q;
        resp_refill_d   = resp_refill_q;
        resp_badvaddr_d = resp_badvaddr_q;

        if (flush) begin
            resp_valid_d = 1'b0;
        end else if (q1_advance) begin
            resp_valid_d    = 1'b1;
            resp_paddr_d    = x_paddr;
            resp_uncached_d = x_uncached;
            resp_ex_d       = x_ex;
            resp_excode_d   = x_excode;
            resp_refill_d   = x_refill;
            resp_badvaddr_d = q1_vaddr_q;
        end else if (q2_free) begin
            // Consumer took the response and nothing is behind it.
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q1_valid_q      <= 1'b0;
            q1_vaddr_q      <= 32'd0;
            q1_wr_q         <= 1'b0;
            q1_asid_q       <= 8'd0;
            resp_valid_q    <= 1'b0;
            resp_paddr_q    <= 32'd0;
            resp_uncached_q <= 1'b0;
            resp_ex_q       <= 1'b0;
            resp_excode_q   <= 5'd0;
            resp_refill_q   <= 1'b0;
            resp_badvaddr_q <= 32'd0;
        end else begin
            q1_valid_q      <= q1_valid_d;
            q1_vaddr_q      <= q1_vaddr_d;
            q1_wr_q         <= q1_wr_d;
            q1_asid_q       <= q1_asid_d;
            resp_valid_q    <= resp_valid_d;
            resp_paddr_q    <= resp_paddr_d;
            resp_uncached_q <= resp_uncached_d;
            resp_ex_q       <= resp_ex_d;
            resp_excode_q   <= resp_excode_d;
            resp_refill_q   <= resp_refill_d;
            resp_badvaddr_q <= resp_badvaddr_d;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_paddr    = resp_paddr_q;
    assign resp_uncached = resp_uncached_q;
    assign resp_ex       = resp_ex_q;
    assign resp_excode   = resp_excode_q;
    assign resp_refill   = resp_refill_q;
    assign resp_badvaddr = resp_badvaddr_q;

endmodule
